// File: rtl/burst_mem_pkg.sv
// Shared types for the burst memory responder: command encoding, FSM states
// and the fixed burst length.
package burst_mem_pkg;

  localparam int BURST_LENGTH = 8;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_READ  = 2'd2
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    REFRESH,
    READ_WAIT,
    READ_BURST,
    WRITE_BEAT,
    WRITE_HOLD
  } state_e;

endpackage

// File: rtl/burst_mem_ram.sv
// Single-port 16-bit word store with a one-cycle registered, read-first output.
module burst_mem_ram #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  // NOTE: the array has no reset so it maps onto block RAM and keeps its contents across reset.
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/burst_mem_responder.sv
// Fixed 8-word wrapping burst responder in front of an on-chip word store,
// with periodic refresh stalls and a sticky protocol error flag.
module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int READ_LATENCY     = 3,
  parameter int WRITE_GAP        = 2,
  parameter int MEM_ADDR_WIDTH   = 12,
  parameter int REFRESH_INTERVAL = 1092,
  parameter int REFRESH_CYCLES   = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  command,
  input  logic [21:0] data_address,
  input  logic [15:0] data_write,
  output logic [15:0] data_read,
  output logic        data_read_valid,
  output logic        data_write_done,
  output logic        busy,
  output logic        protocol_error
);

  state_e                    r_state, w_state_nxt;
  logic [7:0]                r_cnt, w_cnt_nxt;
  logic [3:0]                r_beat, w_beat_nxt;
  logic [MEM_ADDR_WIDTH-1:0] r_addr;
  logic [1:0]                r_cmd;
  logic [15:0]               r_ref_cnt;
  logic                      r_ref_pend;
  logic                      r_perr;

  logic                      w_decide, w_accept, w_take_ref;
  logic                      w_expire, w_ref_req, w_in_burst, w_we;
  logic [2:0]                w_beat_sel;
  logic [MEM_ADDR_WIDTH-1:0] w_ram_addr;
  logic [15:0]               w_ram_q;
  logic                      w_unused_addr;

  assign w_unused_addr = &{1'b0, data_address[21:MEM_ADDR_WIDTH]};

  assign w_expire   = (REFRESH_INTERVAL != 0) && (r_ref_cnt == '0);
  assign w_ref_req  = r_ref_pend | w_expire;
  assign w_in_burst = r_state inside {READ_WAIT, READ_BURST, WRITE_BEAT, WRITE_HOLD};

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_beat_nxt  = r_beat;
    w_decide    = 1'b0;
    w_accept    = 1'b0;
    w_take_ref  = 1'b0;
    case (r_state)
      IDLE: w_decide = 1'b1;
      REFRESH:
        if (r_cnt == 8'(REFRESH_CYCLES - 1)) w_decide = 1'b1;
        else                                 w_cnt_nxt = r_cnt + 8'd1;
      READ_WAIT:
        if (r_cnt == 8'(READ_LATENCY - 1)) w_state_nxt = READ_BURST;
        else                               w_cnt_nxt = r_cnt + 8'd1;
      READ_BURST:
        if (r_beat == 4'(BURST_LENGTH - 1)) w_state_nxt = IDLE;
        else                                w_beat_nxt = r_beat + 4'd1;
      WRITE_BEAT: begin
        w_beat_nxt = r_beat + 4'd1;
        w_cnt_nxt  = '0;
        if (WRITE_GAP != 0)                      w_state_nxt = WRITE_HOLD;
        else if (r_beat == 4'(BURST_LENGTH - 1)) w_state_nxt = IDLE;
      end
      WRITE_HOLD:
        if (r_cnt == 8'(WRITE_GAP - 1))
          w_state_nxt = (r_beat == 4'(BURST_LENGTH)) ? IDLE : WRITE_BEAT;
        else
          w_cnt_nxt = r_cnt + 8'd1;
      default: w_state_nxt = IDLE;
    endcase

    // The last refresh cycle decides like IDLE so a held command is taken on the same edge.
    if (w_decide) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_beat_nxt  = '0;
      if (w_ref_req) begin
        w_state_nxt = REFRESH;
        w_take_ref  = 1'b1;
      end else if (command == CMD_READ) begin
        w_state_nxt = READ_WAIT;
        w_accept    = 1'b1;
      end else if (command == CMD_WRITE) begin
        w_state_nxt = WRITE_BEAT;
        w_accept    = 1'b1;
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_beat     <= '0;
      r_addr     <= '0;
      r_cmd      <= CMD_IDLE;
      r_ref_cnt  <= 16'(REFRESH_INTERVAL - 1);
      r_ref_pend <= 1'b0;
      r_perr     <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_beat     <= w_beat_nxt;
      r_ref_cnt  <= (r_ref_cnt == '0) ? 16'(REFRESH_INTERVAL - 1) : r_ref_cnt - 16'd1;
      r_ref_pend <= (r_ref_pend | w_expire) & ~w_take_ref;
      if (w_accept) begin
        r_addr <= data_address[MEM_ADDR_WIDTH-1:0];
        r_cmd  <= command;
      end
      if (w_in_burst && (command != r_cmd)) r_perr <= 1'b1;
    end
  end

  // Reads present the next beat's address one cycle early to cover the RAM register.
  assign w_beat_sel = (r_state == READ_BURST) ? (r_beat[2:0] + 3'd1) : r_beat[2:0];
  assign w_ram_addr = {r_addr[MEM_ADDR_WIDTH-1:3], r_addr[2:0] + w_beat_sel};
  assign w_we       = (r_state == WRITE_BEAT) & ~reset;

  burst_mem_ram #(
    .ADDR_WIDTH (MEM_ADDR_WIDTH),
    .DATA_WIDTH (16)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_ram_addr),
    .i_wdata (data_write),
    .o_rdata (w_ram_q)
  );

  assign busy            = (r_state != IDLE);
  assign data_read_valid = (r_state == READ_BURST);
  assign data_write_done = (r_state == WRITE_BEAT);
  assign data_read       = data_read_valid ? w_ram_q : '0;
  assign protocol_error  = r_perr;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder: bursts, wrap order, aliasing,
// protocol error, reset mid-burst and refresh stalls on a second instance.
module tb_burst_mem_responder;
  import burst_mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, reset_r;
  logic [1:0]  command, command_r;
  logic [21:0] data_address, data_address_r;
  logic [15:0] data_write, data_write_r;
  logic [15:0] data_read, data_read_r;
  logic        data_read_valid, data_read_valid_r;
  logic        data_write_done, data_write_done_r;
  logic        busy, busy_r;
  logic        protocol_error, protocol_error_r;

  burst_mem_responder #(
    .REFRESH_INTERVAL (0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .command         (command),
    .data_address    (data_address),
    .data_write      (data_write),
    .data_read       (data_read),
    .data_read_valid (data_read_valid),
    .data_write_done (data_write_done),
    .busy            (busy),
    .protocol_error  (protocol_error)
  );

  burst_mem_responder #(
    .REFRESH_INTERVAL (20)
  ) dut_ref (
    .clk             (clk),
    .reset           (reset_r),
    .command         (command_r),
    .data_address    (data_address_r),
    .data_write      (data_write_r),
    .data_read       (data_read_r),
    .data_read_valid (data_read_valid_r),
    .data_write_done (data_write_done_r),
    .busy            (busy_r),
    .protocol_error  (protocol_error_r)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] wr_words [8];
  logic [15:0] rd_exp   [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(data_read_valid), 32'd0);
    check({tag, "_done"},  32'(data_write_done), 32'd0);
    check({tag, "_perr"},  32'(protocol_error), 32'd0);
    check({tag, "_data"},  32'(data_read), 32'd0);
  endtask

  // Cycle c is the cycle after edge c following acceptance; beats land on c = 0,3,...,21.
  task automatic write_burst(input logic [21:0] addr, input int reset_at_beat);
    bit aborted = 1'b0;
    command      = CMD_WRITE;
    data_address = addr;
    data_write   = wr_words[0];
    for (int c = 0; c <= 24 && !aborted; c++) begin
      step();
      if ((c % 3 == 0) && (c <= 21)) data_write = wr_words[c / 3];
      if ((reset_at_beat >= 0) && (c == 3 * reset_at_beat)) begin
        check("wr_done_before_reset", 32'(data_write_done), 32'd1);
        reset = 1'b1;
        step();
        check_reset_outputs("mid_burst_reset");
        reset   = 1'b0;
        command = CMD_IDLE;
        step();
        aborted = 1'b1;
      end else begin
        check("wr_done", 32'(data_write_done), 32'((c % 3 == 0) && (c <= 21)));
        check("wr_busy", 32'(busy), 32'(c < 24));
        if (c == 24) command = CMD_IDLE;
      end
    end
  endtask

  // Beats are expected on c = 3..10 (READ_LATENCY = 3); c = 11 must be IDLE.
  task automatic read_burst(input logic [21:0] addr, input int change_beat);
    command      = CMD_READ;
    data_address = addr;
    for (int c = 0; c <= 11; c++) begin
      step();
      check("rd_valid", 32'(data_read_valid), 32'((c >= 3) && (c <= 10)));
      if ((c >= 3) && (c <= 10)) check("rd_data", 32'(data_read), 32'(rd_exp[c - 3]));
      check("rd_busy", 32'(busy), 32'(c < 11));
      if ((change_beat >= 0) && (c == 3 + change_beat)) command = CMD_WRITE;
      if (c == 11) command = CMD_IDLE;
    end
  endtask

  initial begin
    reset = 1'b1;  command = CMD_IDLE;  data_address = '0;  data_write = '0;
    reset_r = 1'b1; command_r = CMD_IDLE; data_address_r = '0; data_write_r = '0;

    step();
    step();
    check_reset_outputs("reset");
    reset = 1'b0;
    step();

    // Reserved command in IDLE is ignored.
    command = 2'd3;
    repeat (3) step();
    check("cmd3_busy", 32'(busy), 32'd0);
    check("cmd3_perr", 32'(protocol_error), 32'd0);
    command = CMD_IDLE;
    step();

    // Write 0x1000.. at 8 and read it back.
    for (int i = 0; i < 8; i++) begin
      wr_words[i] = 16'h1000 + 16'(i);
      rd_exp[i]   = 16'h1000 + 16'(i);
    end
    write_burst(22'h000008, -1);
    read_burst(22'h000008, -1);

    // Index values in words 8..15, read from 13 wraps within the burst.
    for (int i = 0; i < 8; i++) wr_words[i] = 16'(8 + i);
    write_burst(22'h000008, -1);
    rd_exp = '{16'd13, 16'd14, 16'd15, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12};
    read_burst(22'h00000D, -1);
    check("perr_clean", 32'(protocol_error), 32'd0);

    // High address bits alias onto word 8; command flips at beat 3.
    for (int i = 0; i < 8; i++) rd_exp[i] = 16'(8 + i);
    read_burst(22'h3FF008, 3);
    check("perr_set", 32'(protocol_error), 32'd1);
    repeat (3) step();
    check("perr_sticky", 32'(protocol_error), 32'd1);

    // Reset during write beat 4: words 0..3 new, 4..7 old.
    for (int i = 0; i < 8; i++) wr_words[i] = 16'hA000 + 16'(i);
    write_burst(22'h000000, -1);
    for (int i = 0; i < 8; i++) wr_words[i] = 16'hB000 + 16'(i);
    write_burst(22'h000000, 4);
    rd_exp = '{16'hB000, 16'hB001, 16'hB002, 16'hB003,
               16'hA004, 16'hA005, 16'hA006, 16'hA007};
    read_burst(22'h000000, -1);

    // Refresh instance: expiry is visible 19 cycles after the reset edge.
    reset_r = 1'b0;
    step();
    check("ref_rst_data", 32'(data_read_r), 32'd0);
    check("ref_rst_done", 32'(data_write_done_r), 32'd0);
    repeat (18) step();
    check("ref_idle_busy", 32'(busy_r), 32'd0);
    command_r = CMD_READ;
    for (int c = 1; c <= 31; c++) begin
      step();
      if (c <= 12)      check("ref_stall", 32'({busy_r, data_read_valid_r}), 32'b10);
      else if (c <= 20) check("ref_rd_valid", 32'(data_read_valid_r), 32'd1);
      if (c == 21) begin
        check("ref_idle_after_burst", 32'(busy_r), 32'd0);
        command_r = CMD_IDLE;
      end
      if (c == 22) check("ref_pending_start", 32'(busy_r), 32'd1);
      if (c == 30) check("ref_pending_last", 32'(busy_r), 32'd1);
      if (c == 31) check("ref_pending_end", 32'(busy_r), 32'd0);
    end
    check("ref_perr", 32'(protocol_error_r), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/burst_mem_responder.md
BURST_MEM_RESPONDER -- requirements
Module: burst_mem_responder

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 3, meaning cycles from read acceptance to the first data_read_valid beat (range 1..7).
REQ-002 SHALL have parameter WRITE_GAP, default 2, meaning idle cycles after each data_write_done before the next write word is sampled.
REQ-003 SHALL have parameter MEM_ADDR_WIDTH, default 12, meaning the number of low data_address bits that index the on-chip 16-bit word store.
REQ-004 SHALL have parameter REFRESH_INTERVAL, default 1092, meaning cycles between refresh requests; 0 disables refresh.
REQ-005 SHALL have parameter REFRESH_CYCLES, default 9, meaning stall length of one refresh.
REQ-006 clk  input  1  sole clock; every register updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 command  input  2  encoding: 0 idle, 1 write burst, 2 read burst, 3 reserved and treated as idle.
REQ-009 data_address  input  22  burst start word address; sampled only at acceptance.
REQ-010 data_write  input  16  current write word.
REQ-011 data_read  output  16  read word; valid only while data_read_valid is high.
REQ-012 data_read_valid  output  1  one-cycle strobe per read beat.
REQ-013 data_write_done  output  1  one-cycle strobe per consumed write word.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 protocol_error  output  1  sticky flag; cleared only by reset.

Function
REQ-016 Burst length SHALL be fixed at 8 words, sequential order, with the low 3 address bits wrapping: beat i uses {a[MEM_ADDR_WIDTH-1:3], a[2:0]+i}.
REQ-017 States SHALL be IDLE, REFRESH, READ_WAIT, READ_BURST, WRITE_BEAT and WRITE_HOLD.
REQ-018 In IDLE, a pending refresh SHALL take priority: go to REFRESH for REFRESH_CYCLES cycles, then return to IDLE; a command arriving meanwhile SHALL wait, holding.
REQ-019 IDLE with no refresh pending and command 2 SHALL latch the address and go to READ_WAIT.
REQ-020 IDLE with no refresh pending and command 1 SHALL latch the address and go to WRITE_BEAT.
REQ-021 The first data_read_valid SHALL occur exactly READ_LATENCY cycles after the acceptance edge.
REQ-022 Read beats SHALL then be 8 consecutive cycles with no gaps.
REQ-023 After beat 7 the block SHALL enter IDLE, and SHALL not accept a new command on the beat-7 cycle.
REQ-024 WRITE_BEAT SHALL write data_write to the current beat address and pulse data_write_done in the same cycle.
REQ-025 After each write beat the block SHALL enter WRITE_HOLD for WRITE_GAP cycles, then return to WRITE_BEAT, or to IDLE after beat 7.
REQ-026 The refresh counter SHALL run continuously; an expiry during a burst SHALL set a pending flag serviced at the next IDLE; a second expiry while the flag is pending SHALL not queue a second refresh.
REQ-027 A command value other than the accepted one during a burst SHALL set protocol_error; the burst SHALL still complete unchanged.
REQ-028 Command 0 or 3 in IDLE SHALL do nothing and never set protocol_error.
REQ-029 Address bits above MEM_ADDR_WIDTH SHALL be ignored, aliasing the store.
REQ-030 Read-after-write to the same address SHALL return the written data (RAM read-first latency is hidden inside READ_LATENCY).

Reset
REQ-031 Reset SHALL force IDLE, busy=0, data_read_valid=0, data_write_done=0, protocol_error=0, data_read=0, clear beat and gap counters, clear the refresh pending flag, and reload the refresh counter.
REQ-032 Reset mid-burst SHALL abort the burst; no strobe SHALL appear in the cycle after reset is sampled.
REQ-033 Memory contents SHALL not be cleared by reset.

Structure
REQ-034 Package burst_mem_pkg SHALL hold the command enum (CMD_IDLE, CMD_WRITE, CMD_READ), the state enum and BURST_LENGTH=8.
REQ-035 Sub-module burst_mem_ram SHALL be a single-port 16-bit synchronous RAM with one-cycle registered read, inferred as block RAM.

Verification
REQ-036 Write burst at 0x000008 of 0x1000..0x1007, then read at 0x000008 -> data_write_done pulses every 3 cycles; read returns 0x1000..0x1007 starting 3 cycles after acceptance.
REQ-037 Read at 0x00000D after filling words 8..15 with index values -> beats return 13,14,15,8,9,10,11,12.
REQ-038 REFRESH_INTERVAL=20; request a read at the cycle of expiry -> acceptance delayed 9 cycles; busy stays high throughout.
REQ-039 Change command 2 to 1 at beat 3 -> protocol_error=1 and remains set; all 8 read beats still delivered.
REQ-040 Assert reset at write beat 4, then issue a read burst -> outputs at reset values next cycle; words 0..3 hold new data, words 4..7 keep old data.
